wb_retire_queue: RTL and testbench

Parametrised writeback stage for the LoongArch pipeline. It replaces the single-register MEM→WB latch with a DEPTH-entry in-order retire buffer that drains through the register-file write port under an `rf_ready` backpressure input. It forwards to decode from every buffered entry, youngest match first, and raises a one-cycle precise-exception flush when a faulting instruction reaches the head. It sits between the MEM stage and the register file and debug trace port.

---
 rtl/wb_retire_queue.sv | 137 +++++++++++++
 tb/tb_wb_retire_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wb_retire_queue.sv
// In-order writeback retire buffer between MEM and the register file.
// Forwards from every buffered entry and raises a one-cycle flush when a faulting entry retires.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int EXC_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic              ms_gr_we,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic [PC_W-1:0]   ms_pc,
  input  logic              ms_is_exc,
  input  logic [EXC_W-1:0]  ms_exc_code,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_AW-1:0] ds_rj,
  input  logic [REG_AW-1:0] ds_rk,
  output logic              fwd_rj_hit,
  output logic              fwd_rk_hit,
  output logic [DATA_W-1:0] fwd_rj_data,
  output logic [DATA_W-1:0] fwd_rk_data,
  output logic              ws_flush,
  output logic [PC_W-1:0]   ws_flush_pc,
  output logic [EXC_W-1:0]  ws_flush_code,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   pc;
    logic              is_exc;
    logic [EXC_W-1:0]  code;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head_e;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              non_empty, retire, push;
  logic [PTR_W-1:0]  scan_idx;

  assign head_e    = mem_q[head_q];
  assign non_empty = (count_q != '0);
  assign ws_allowin = (count_q != FULL);
  // Gating with reset keeps the reset cycle free of RF writes and flushes.
  assign retire    = non_empty && rf_ready && !reset;
  assign ws_flush  = retire && head_e.is_exc;
  assign push      = ms_to_ws_valid && ws_allowin && !ws_flush;

  // Entry storage is not reset; slots outside head..tail are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{gr_we: ms_gr_we, dest: ms_dest, result: ms_result,
                         pc: ms_pc, is_exc: ms_is_exc, code: ms_exc_code};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (ws_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)   tail_d = tail_q + 1'b1;
      if (retire) head_d = head_q + 1'b1;
      if (push && !retire)      count_d = count_q + 1'b1;
      else if (!push && retire) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    rf_we             = retire && head_e.gr_we && !head_e.is_exc;
    rf_waddr          = non_empty ? head_e.dest   : '0;
    rf_wdata          = non_empty ? head_e.result : '0;
    ws_flush_pc       = ws_flush ? head_e.pc   : '0;
    ws_flush_code     = ws_flush ? head_e.code : '0;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_pc       = non_empty ? head_e.pc     : '0;
    debug_wb_rf_wnum  = non_empty ? head_e.dest   : '0;
    debug_wb_rf_wdata = non_empty ? head_e.result : '0;
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_rj_hit  = 1'b0;
    fwd_rk_hit  = 1'b0;
    fwd_rj_data = '0;
    fwd_rk_data = '0;
    scan_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && mem_q[scan_idx].gr_we && !mem_q[scan_idx].is_exc) begin
        if (ds_rj != '0 && mem_q[scan_idx].dest == ds_rj) begin
          fwd_rj_hit  = 1'b1;
          fwd_rj_data = mem_q[scan_idx].result;
        end
        if (ds_rk != '0 && mem_q[scan_idx].dest == ds_rk) begin
          fwd_rk_hit  = 1'b1;
          fwd_rk_data = mem_q[scan_idx].result;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed and random stimulus for wb_retire_queue, checked every cycle against a
// queue-based reference model of the retire buffer.
module tb_wb_retire_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid, ms_gr_we, ms_is_exc, rf_ready;
  logic [4:0]  ms_dest, ds_rj, ds_rk;
  logic [31:0] ms_result, ms_pc;
  logic [5:0]  ms_exc_code;
  logic        ws_allowin, rf_we, fwd_rj_hit, fwd_rk_hit, ws_flush;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, fwd_rj_data, fwd_rk_data, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [5:0]  ws_flush_code;
  logic [3:0]  debug_wb_rf_we;

  int n_checks = 0;
  int n_fail   = 0;
  int max_occ  = 0;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] pc;
    logic        exc;
    logic [5:0]  code;
  } ent_t;
  ent_t q[$];

  wb_retire_queue #(.DATA_W(32), .PC_W(32), .REG_AW(5), .DEPTH(DEPTH), .EXC_W(6)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
    .ms_is_exc(ms_is_exc), .ms_exc_code(ms_exc_code),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ds_rj(ds_rj), .ds_rk(ds_rk),
    .fwd_rj_hit(fwd_rj_hit), .fwd_rk_hit(fwd_rk_hit),
    .fwd_rj_data(fwd_rj_data), .fwd_rk_data(fwd_rk_data),
    .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .ws_flush_code(ws_flush_code),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fwd_ref(input logic [4:0] a, output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (a != 0 && q[i].we && !q[i].exc && q[i].dest == a) begin
        hit = 1'b1;
        data = q[i].res;
        break;
      end
    end
  endtask

  // One clock: inputs already applied; check mid-cycle, then advance the model at the edge.
  task automatic cyc(input logic rst, input logic v, input logic we, input logic [4:0] d,
                     input logic [31:0] r, input logic [31:0] pc, input logic exc,
                     input logic [5:0] code, input logic rdy, input logic [4:0] rj,
                     input logic [4:0] rk);
    logic        empty, ret, e_we, e_fl, e_allow, jh, kh;
    logic [31:0] jd, kd;
    ent_t        h, n;
    reset = rst; ms_to_ws_valid = v; ms_gr_we = we; ms_dest = d; ms_result = r;
    ms_pc = pc; ms_is_exc = exc; ms_exc_code = code; rf_ready = rdy; ds_rj = rj; ds_rk = rk;
    @(negedge clk);
    empty   = (q.size() == 0);
    e_allow = (q.size() != DEPTH);
    h       = empty ? '{1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 6'd0} : q[0];
    ret     = !empty && rdy && !rst;
    e_we    = ret && h.we && !h.exc;
    e_fl    = ret && h.exc;
    chk("allowin", 64'(ws_allowin), 64'(e_allow));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("dbg_we", 64'(debug_wb_rf_we), 64'({4{e_we}}));
    chk("flush", 64'(ws_flush), 64'(e_fl));
    chk("flush_pc", 64'(ws_flush_pc), e_fl ? 64'(h.pc) : 64'd0);
    chk("flush_code", 64'(ws_flush_code), e_fl ? 64'(h.code) : 64'd0);
    chk("waddr", 64'(rf_waddr), 64'(h.dest));
    chk("wdata", 64'(rf_wdata), 64'(h.res));
    chk("dbg_pc", 64'(debug_wb_pc), 64'(h.pc));
    chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
    chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(h.res));
    fwd_ref(rj, jh, jd);
    fwd_ref(rk, kh, kd);
    chk("rj_hit", 64'(fwd_rj_hit), 64'(jh));
    chk("rj_data", 64'(fwd_rj_data), 64'(jd));
    chk("rk_hit", 64'(fwd_rk_hit), 64'(kh));
    chk("rk_data", 64'(fwd_rk_data), 64'(kd));
    @(posedge clk);
    n = '{we, d, r, pc, exc, code};
    if (rst || e_fl) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (v && e_allow) q.push_back(n);
    end
    if (q.size() > max_occ) max_occ = q.size();
    #1;
  endtask

  task automatic idle(input logic rdy, input logic [4:0] rj);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 6'd0, rdy, rj, 5'd0);
  endtask

  initial begin
    // reset
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 6'd0, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd0, 5'd0);
    // single push, immediate retire
    cyc(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 32'h1c000000, 1'b0, 6'd0, 1'b1, 5'd5, 5'd0);
    idle(1'b1, 5'd5);
    idle(1'b1, 5'd5);
    // fill under backpressure, forward youngest, then drain
    cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hA, 32'h1c000004, 1'b0, 6'd0, 1'b0, 5'd3, 5'd3);
    cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hB, 32'h1c000008, 1'b0, 6'd0, 1'b0, 5'd3, 5'd3);
    cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'hC, 32'h1c00000c, 1'b0, 6'd0, 1'b0, 5'd3, 5'd9);
    idle(1'b1, 5'd3);
    idle(1'b1, 5'd3);
    idle(1'b1, 5'd3);
    // exception followed by r7; flush discards r7
    cyc(1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 32'h1c000010, 1'b1, 6'h0b, 1'b0, 5'd4, 5'd7);
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 32'h55, 32'h1c000014, 1'b0, 6'd0, 1'b0, 5'd4, 5'd7);
    cyc(1'b0, 1'b1, 1'b1, 5'd8, 32'h66, 32'h1c000018, 1'b0, 6'd0, 1'b1, 5'd4, 5'd7);
    idle(1'b1, 5'd7);
    // exception with dest=4 and rf_ready=1 while a push arrives in the flush cycle
    cyc(1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 32'h1c000020, 1'b1, 6'h03, 1'b1, 5'd4, 5'd0);
    cyc(1'b0, 1'b1, 1'b1, 5'd6, 32'h77, 32'h1c000024, 1'b0, 6'd0, 1'b1, 5'd4, 5'd6);
    idle(1'b1, 5'd6);
    // r0 entry never forwards but still writes
    cyc(1'b0, 1'b1, 1'b1, 5'd0, 32'h99, 32'h1c000030, 1'b0, 6'd0, 1'b0, 5'd0, 5'd0);
    idle(1'b1, 5'd0);
    // 8 back-to-back with rf_ready=1
    max_occ = 0;
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b1, 5'(i + 10), 32'(i * 17 + 3), 32'h1c000100 + 32'(i * 4),
          1'b0, 6'd0, 1'b1, 5'(i + 9), 5'(i + 10));
    idle(1'b1, 5'd0);
    n_checks++;
    assert (max_occ <= 1) else begin
      n_fail++;
      $error("FAIL b2b_occupancy observed=%0d expected<=1", max_occ);
    end
    // reset with two entries buffered
    cyc(1'b0, 1'b1, 1'b1, 5'd1, 32'h11, 32'h1c000200, 1'b0, 6'd0, 1'b0, 5'd1, 5'd2);
    cyc(1'b0, 1'b1, 1'b1, 5'd2, 32'h22, 32'h1c000204, 1'b0, 6'd0, 1'b0, 5'd1, 5'd2);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 6'd0, 1'b1, 5'd1, 5'd2);
    idle(1'b1, 5'd1);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 60) == 0, $urandom % 2, $urandom % 4 != 0, 5'($urandom % 8),
          $urandom, $urandom, ($urandom % 8) == 0, 6'($urandom), ($urandom % 10) < 6,
          5'($urandom % 8), 5'($urandom % 8));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
